// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared event indices, entry type and sizing helper for the perf counter bank
package perf_pkg;

    localparam int EV_DCACHE_STALL = 0;
    localparam int EV_ICACHE_STALL = 1;
    localparam int EV_FLUSH        = 2;
    localparam int EV_DC_HIT       = 3;
    localparam int EV_DC_MISS      = 4;
    localparam int EV_IC_HIT       = 5;
    localparam int EV_IC_MISS      = 6;
    localparam int EV_BR_TOTAL     = 7;
    localparam int EV_JALR         = 8;
    localparam int EV_BTB_OK       = 9;
    localparam int EV_RAS_OK       = 10;
    localparam int EV_TOURN_OK     = 11;

    localparam int PKG_CNT_WIDTH = 32;

    typedef struct packed {
        logic [PKG_CNT_WIDTH-1:0] cnt;
        logic                     ovf;
    } perf_entry_t;

    // A single-channel bank still needs a 1-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// rtl/perf_counter_slice.sv - one live event counter with sticky overflow, wrap or clamp
module perf_counter_slice #(
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 2,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INC_WIDTH-1:0] inc,
    input  logic                 inc_ok,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        // clear wins over any increment presented in the same cycle
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_ok) begin
            if (sum[CNT_WIDTH]) begin
                ovf_d = 1'b1;
                cnt_d = (SATURATE != 0) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
            end else begin
                cnt_d = sum[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of gated event counters with atomic shadow snapshot and indexed readout
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter  int NUM_EVENTS = 16,
    parameter  int CNT_WIDTH  = 32,
    parameter  int INC_WIDTH  = 2,
    parameter  int SATURATE   = 0,
    localparam int IDX_W      = idx_width(NUM_EVENTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_EVENTS*INC_WIDTH-1:0] event_inc,
    input  logic                            stall,
    input  logic [NUM_EVENTS-1:0]           gate_mask,
    input  logic                            cnt_en,
    input  logic                            clear,
    input  logic                            snap,
    input  logic                            rd_req,
    input  logic [IDX_W-1:0]                rd_idx,
    output logic                            rd_valid,
    output logic [CNT_WIDTH-1:0]            rd_data,
    output logic                            rd_ovf,
    output logic [NUM_EVENTS-1:0]           ovf_flags
);

    logic [NUM_EVENTS-1:0] inc_ok;
    logic [CNT_WIDTH-1:0]  live_cnt [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] live_ovf;

    logic [CNT_WIDTH-1:0]  shd_cnt_q [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  shd_cnt_d [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] shd_ovf_q, shd_ovf_d;

    logic                  rd_valid_q, rd_valid_d;
    logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                  rd_ovf_q, rd_ovf_d;
    logic                  idx_in_range;

    // Gated channels ignore events while the pipeline is stalled.
    assign inc_ok = {NUM_EVENTS{cnt_en}} & ~(gate_mask & {NUM_EVENTS{stall}});

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_slice
        perf_counter_slice #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (INC_WIDTH),
            .SATURATE  (SATURATE)
        ) u_slice (
            .clk    (clk),
            .rst_n  (rst),
            .inc    (event_inc[i*INC_WIDTH +: INC_WIDTH]),
            .inc_ok (inc_ok[i]),
            .clear  (clear),
            .cnt    (live_cnt[i]),
            .ovf    (live_ovf[i])
        );
    end

    // Shadow takes the live registers as they stand before this edge's update.
    always_comb begin
        shd_cnt_d = shd_cnt_q;
        shd_ovf_d = shd_ovf_q;
        if (snap) begin
            shd_cnt_d = live_cnt;
            shd_ovf_d = live_ovf;
        end
    end

    assign idx_in_range = (32'(rd_idx) < 32'(NUM_EVENTS));

    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_data_q;
        rd_ovf_d   = rd_ovf_q;
        if (rd_req) begin
            if (idx_in_range) begin
                rd_data_d = shd_cnt_q[rd_idx];
                rd_ovf_d  = shd_ovf_q[rd_idx];
            end else begin
                rd_data_d = '0;
                rd_ovf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                shd_cnt_q[i] <= '0;
            end
            shd_ovf_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            shd_cnt_q  <= shd_cnt_d;
            shd_ovf_q  <= shd_ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_ovf_q   <= rd_ovf_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_ovf    = rd_ovf_q;
    assign ovf_flags = live_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - scoreboard bench driving a wrapping and a saturating bank in lockstep
module tb_perf_counter_bank;

    localparam int N    = 12;
    localparam int CW   = 8;
    localparam int IW   = 2;
    localparam int IDXW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*IW-1:0] event_inc;
    logic            stall;
    logic [N-1:0]    gate_mask;
    logic            cnt_en, clear, snap, rd_req;
    logic [IDXW-1:0] rd_idx;

    logic            rd_valid_w, rd_ovf_w, rd_valid_s, rd_ovf_s;
    logic [CW-1:0]   rd_data_w, rd_data_s;
    logic [N-1:0]    ovf_flags_w, ovf_flags_s;

    perf_counter_bank #(.NUM_EVENTS(N), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .event_inc(event_inc), .stall(stall), .gate_mask(gate_mask),
        .cnt_en(cnt_en), .clear(clear), .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid_w), .rd_data(rd_data_w), .rd_ovf(rd_ovf_w), .ovf_flags(ovf_flags_w)
    );

    perf_counter_bank #(.NUM_EVENTS(N), .CNT_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .event_inc(event_inc), .stall(stall), .gate_mask(gate_mask),
        .cnt_en(cnt_en), .clear(clear), .snap(snap), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid_s), .rd_data(rd_data_s), .rd_ovf(rd_ovf_s), .ovf_flags(ovf_flags_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 = wrapping bank, index 1 = saturating bank.
    int m_cnt [2][N];
    bit m_ovf [2][N];
    int m_shd [2][N];
    bit m_shdo[2][N];

    typedef struct {
        int due;
        int d0;
        int d1;
        bit o0;
        bit o1;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) begin
                m_cnt[d][i] = 0; m_ovf[d][i] = 0; m_shd[d][i] = 0; m_shdo[d][i] = 0;
            end
    endtask

    task automatic idle();
        event_inc = '0; stall = 0; gate_mask = '0; cnt_en = 1;
        clear = 0; snap = 0; rd_req = 0; rd_idx = '0;
    endtask

    task automatic set_inc(input int ch, input int v);
        event_inc[ch*IW +: IW] = IW'(v);
    endtask

    // Called just after a rising edge with inputs already set; advances one cycle.
    task automatic step();
        exp_t e;
        int   vw, vs, inc, sum;
        bit   ok;
        vw = 0; vs = 0;
        for (int i = 0; i < N; i++) begin
            vw |= int'(m_ovf[0][i]) << i;
            vs |= int'(m_ovf[1][i]) << i;
        end
        chk("ovf_flags_wrap", int'(ovf_flags_w), vw);
        chk("ovf_flags_sat", int'(ovf_flags_s), vs);
        if (rd_req) begin
            e.due = cyc + 1;
            if (int'(rd_idx) < N) begin
                e.d0 = m_shd[0][rd_idx]; e.o0 = m_shdo[0][rd_idx];
                e.d1 = m_shd[1][rd_idx]; e.o1 = m_shdo[1][rd_idx];
            end else begin
                e.d0 = 0; e.o0 = 0; e.d1 = 0; e.o1 = 0;
            end
            sb_q.push_back(e);
        end
        for (int d = 0; d < 2; d++) begin
            if (snap) begin
                m_shd[d]  = m_cnt[d];
                m_shdo[d] = m_ovf[d];
            end
            for (int i = 0; i < N; i++) begin
                inc = int'(event_inc[i*IW +: IW]);
                ok  = cnt_en && !(gate_mask[i] && stall);
                if (clear) begin
                    m_cnt[d][i] = 0; m_ovf[d][i] = 0;
                end else if (ok) begin
                    sum = m_cnt[d][i] + inc;
                    if (sum > CMAX) begin
                        m_ovf[d][i] = 1;
                        m_cnt[d][i] = (d == 0) ? sum - (CMAX + 1) : CMAX;
                    end else begin
                        m_cnt[d][i] = sum;
                    end
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Replace the model's prediction for the most recent read with literal values.
    task automatic expect_last(input int d0, input bit o0, input int d1, input bit o1);
        exp_t e;
        e = sb_q.pop_back();
        e.d0 = d0; e.o0 = o0; e.d1 = d1; e.o1 = o1;
        sb_q.push_back(e);
    endtask

    task automatic read(input int idx);
        rd_req = 1; rd_idx = IDXW'(idx);
        step();
        rd_req = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (rd_valid_w || rd_valid_s) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_rd_valid: got wrap=%0b sat=%0b expected 0", rd_valid_w, rd_valid_s);
                end else begin
                    e = sb_q.pop_front();
                    chk("rd_latency", cyc, e.due);
                    chk("rd_valid_wrap", int'(rd_valid_w), 1);
                    chk("rd_valid_sat", int'(rd_valid_s), 1);
                    chk("rd_data_wrap", int'(rd_data_w), e.d0);
                    chk("rd_ovf_wrap", int'(rd_ovf_w), int'(e.o0));
                    chk("rd_data_sat", int'(rd_data_s), e.d1);
                    chk("rd_ovf_sat", int'(rd_ovf_s), int'(e.o1));
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                n_checks++; n_errors++;
                $display("FAIL missing_rd_valid: got 0 expected 1 (due cycle %0d)", e.due);
            end
        end
    end

    initial begin
        model_reset();
        idle();
        rst = 0;
        // 1. reset with random inputs
        for (int k = 0; k < 6; k++) begin
            event_inc = N*IW'($urandom); stall = 1'($urandom); gate_mask = N'($urandom);
            cnt_en = 1'($urandom); clear = 1'($urandom); snap = 1'($urandom);
            rd_req = 1'($urandom); rd_idx = IDXW'($urandom);
            @(posedge clk);
            #2;
        end
        chk("rst_rd_valid", int'(rd_valid_w) + int'(rd_valid_s), 0);
        chk("rst_rd_data", int'(rd_data_w) + int'(rd_data_s), 0);
        chk("rst_rd_ovf", int'(rd_ovf_w) + int'(rd_ovf_s), 0);
        chk("rst_ovf_flags", int'(ovf_flags_w) + int'(ovf_flags_s), 0);
        idle();
        rst = 1;
        snap = 1; step(); snap = 0;
        read(3); expect_last(0, 0, 0, 0);

        // 2. gating: ch0 gated, ch1 free, stall high on 4 of 10 cycles
        clear = 1; step(); clear = 0;
        set_inc(0, 1); set_inc(1, 1); gate_mask = 12'b01;
        for (int k = 0; k < 10; k++) begin
            stall = (k % 3 == 0);
            step();
        end
        idle(); snap = 1; step(); snap = 0;
        read(0); expect_last(6, 0, 6, 0);
        read(1); expect_last(10, 0, 10, 0);

        // 3/4. wrap versus saturate on channel 4
        clear = 1; step(); clear = 0;
        set_inc(4, 1);
        repeat (254) step();
        set_inc(4, 3); step();
        set_inc(4, 0); snap = 1; step(); snap = 0;
        chk("ovf4_wrap", int'(ovf_flags_w[4]), 1);
        chk("ovf4_sat", int'(ovf_flags_s[4]), 1);
        read(4); expect_last(1, 1, 255, 1);
        set_inc(4, 2); step();
        set_inc(4, 0); snap = 1; step(); snap = 0;
        read(4); expect_last(3, 1, 255, 1);

        // 5. clear and snap together on channel 7
        clear = 1; step(); clear = 0;
        set_inc(7, 1);
        repeat (42) step();
        clear = 1; snap = 1; step(); clear = 0; snap = 0;
        read(7); expect_last(42, 0, 42, 0);
        set_inc(7, 0); snap = 1; step(); snap = 0;
        read(7); expect_last(1, 0, 1, 0);

        // 6. back-to-back reads; first read races a snap and must see the old shadow
        idle();
        for (int k = 0; k < 20; k++) begin
            event_inc = N*IW'($urandom);
            step();
        end
        idle();
        rd_req = 1; rd_idx = 2; snap = 1; step();
        snap = 0; rd_idx = 5; step();
        rd_idx = IDXW'(N + 1); step();
        rd_req = 0; step(); step();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            event_inc = N*IW'($urandom);
            stall     = 1'($urandom);
            gate_mask = N'($urandom);
            cnt_en    = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            snap      = ($urandom_range(0, 7) == 0);
            rd_req    = 1'($urandom);
            rd_idx    = IDXW'($urandom);
            step();
        end
        idle(); step(); step(); step();
        chk("scoreboard_drained", sb_q.size(), 0);

        // reset mid-read drops rd_valid asynchronously
        rd_req = 1; rd_idx = 0; step(); rd_req = 0;
        rst = 0;
        #1;
        chk("midrst_rd_valid", int'(rd_valid_w) + int'(rd_valid_s), 0);
        chk("midrst_ovf_flags", int'(ovf_flags_w) + int'(ovf_flags_s), 0);
        sb_q.delete();
        model_reset();
        @(posedge clk); #2;
        rst = 1;
        read(2); expect_last(0, 0, 0, 0);
        step(); step();
        chk("final_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
